// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and data requesters share one memory port.
// Data wins ties until fetch has been passed over STARVE_MAX times in a row.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STARVE_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [3:0] WAIT_LIM   = 4'(WAIT_CYCLES);

  state_t      state_q,     state_d;
  logic [2:0]  starve_q,    starve_d;
  logic [3:0]  wait_q,      wait_d;
  logic        lat_we_q,    lat_we_d;
  logic        mem_en_q,    mem_en_d;
  logic        mem_we_q,    mem_we_d;
  logic [3:0]  mem_be_q,    mem_be_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] dm_rdata_q,  dm_rdata_d;
  logic        if_ready_q,  if_ready_d;
  logic        dm_ready_q,  dm_ready_d;
  logic        grant_dm;
  logic        grant_if;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    lat_we_d    = lat_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;

    case (state_q)
      IDLE: begin
        grant_dm = dm_req && !(if_req && (starve_q == STARVE_LIM));
        grant_if = if_req && !grant_dm;
        if (grant_dm) begin
          state_d     = ACC_DM;
          wait_d      = '0;
          lat_we_d    = dm_we;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_be_d    = dm_be;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 3'd1;
          end
        end else if (grant_if) begin
          state_d     = ACC_IF;
          wait_d      = '0;
          lat_we_d    = 1'b0;
          mem_en_d    = 1'b1;
          mem_be_d    = '1;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      ACC_IF, ACC_DM: begin
        // First in-access edge closes the mem_en cycle; WAIT_CYCLES more edges follow.
        if (wait_q == WAIT_LIM) begin
          state_d = IDLE;
          wait_d  = '0;
          if (state_q == ACC_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ready_d = 1'b1;
            if (!lat_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      lat_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      lat_we_q    <= lat_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign busy      = (state_q != IDLE);
  assign stall_f   = if_req & ~if_ready_q;
  assign stall_m   = dm_req & ~dm_ready_q;

endmodule
